seg_anim_gen: RTL and testbench
===============================

# seg_anim_gen

Parametrised 7-segment animation generator, the successor to the fixed six-digit heartbeat pattern source. It drives the per-digit segment codes consumed by `LED_mux`, with a configurable digit count, frame period and output polarity. It also adds run-time selection of three animations (heartbeat, perimeter chase, blink), pause, and frame/cycle status pulses. It sits between the board top level and `LED_mux`, one instance per display.

## Interface
- `DIGITS`, 6: digit count; even, 2..8.
- `TICKS`, 6_000_000: clocks per animation frame; ≥2.
- `ACTIVE_LOW`, 1: 1 inverts every segment bit at the output (segment on = 0).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  1 runs the animation; 0 freezes prescaler and frame; outputs hold.
- `mode`  in  2  0 heartbeat, 1 chase, 2 blink, 3 blank.
- `seg_out`  out  8*DIGITS  digit i on bits [8i+7:8i]; digit 0 is rightmost; bit order {dp,g,f,e,d,c,b,a}.
- `frame_tick`  out  1  one-cycle pulse each frame advance.
- `cycle_done`  out  1  one-cycle pulse when the frame index wraps to 0.

## Operation
- Segment constants below are active-high (a=0x01, b=0x02, c=0x04, d=0x08, e=0x10, f=0x20, g=0x40); with `ACTIVE_LOW`=1 every bit of `seg_out` is inverted. dp is always off. H = DIGITS/2.
- Prescaler `cnt` counts 0..TICKS-1 while `en`=1. tick = (`cnt`==TICKS-1 && `en`), after which `cnt` returns to 0.
- Registered `mode_q` holds the active animation. On tick:
  - if `mode` != `mode_q`: load `mode_q`, set frame to 0, no `cycle_done`;
  - else: frame advances modulo the frame count L of `mode_q`, and `cycle_done` pulses on the wrap to 0.
- Heartbeat, L = 2H: distance k = f for f<H, else k = 2H-1-f. Digit H+k shows e|f (0x30); digit H-1-k shows b|c (0x06); all others blank.
- Chase, L = 2·DIGITS+4, one lit segment clockwise:
  - frames 0..DIGITS-1: seg a on digit DIGITS-1-f;
  - frame DIGITS: b on digit 0; frame DIGITS+1: c on digit 0;
  - next DIGITS frames: d on digits 0..DIGITS-1 in order;
  - then e, then f, on digit DIGITS-1.
- Blink, L = 2: frame 0 all digits 0x7F, frame 1 all blank.
- Blank, L = 1: all digits blank; frame stays 0.
- `mode` is sampled only on tick. A change mid-frame is invisible until the current frame period completes.

## Timing
- Reset (async assert):
  - `cnt` = 0, frame = 0, `mode_q` = 0;
  - `seg_out` = heartbeat frame 0 encoding;
  - `frame_tick` = `cycle_done` = 0.
- `seg_out`, `frame_tick` and `cycle_done` are registered and update on the clock edge following the tick cycle. They have one cycle of latency from tick and are combinationally independent of the inputs.
- With `en` held at 1, frames advance every exactly TICKS cycles; the first `frame_tick` comes TICKS cycles after reset release.
- `en`=0 on the tick cycle suppresses that tick; `cnt` holds at TICKS-1 and the tick fires in the first cycle `en` returns to 1.
- Reset asserted mid-frame aborts immediately; the restart is identical to power-up.
- Frame width is $clog2(2·DIGITS+4). `cnt` width is $clog2(TICKS). No arithmetic overflow is permitted; compares are exact-equal.

## Structure
- Package `seg_anim_pkg`:
  - segment bit constants SEG_A..SEG_DP;
  - mode encodings MODE_HEART, MODE_CHASE, MODE_BLINK, MODE_BLANK;
  - function for frame count per mode.
- Sub-module `tick_gen` (parameter TICKS; ports `clk`, `rst_n`, `en`, `tick`) holds the prescaler.
- The frame-to-pattern decode is a combinational function inside `seg_anim_gen`, feeding the output register.

## Test plan
All runs use DIGITS=6, TICKS=4, ACTIVE_LOW=0 unless stated.
- Reset, mode=0, en=1 → `seg_out` 48'h0000_3006_0000 at reset; 48'h0030_0000_0600 after the first tick; 48'h3000_0000_0006 after the second; the 6th tick returns to frame 0 with `cycle_done`=1 for exactly one cycle.
- mode=1 → first tick switches mode; `seg_out` = 48'h0100_0000_0000 (a on digit 5); 16 ticks later `cycle_done` pulses and the pattern repeats.
- mode=2 → 48'h7F7F_7F7F_7F7F, then all zero on alternate frames.
- Same stimulus with ACTIVE_LOW=1, mode=3 → `seg_out` = 48'hFFFF_FFFF_FFFF, `cycle_done` never pulses.
- `en` dropped for 10 cycles mid-frame → `seg_out` and `cnt` frozen; frame period stretches by exactly 10 cycles.
- Assert `rst_n` low for 1 cycle mid-chase → outputs return to heartbeat frame 0 asynchronously; first `frame_tick` 4 cycles after release.

Source files
------------

// File: rtl/seg_anim_pkg.sv
// Shared constants and helpers for the 7-segment animation generator.
// Segment bits are active-high here; output polarity is applied in the top.
package seg_anim_pkg;

  localparam logic [7:0] SEG_A     = 8'h01;
  localparam logic [7:0] SEG_B     = 8'h02;
  localparam logic [7:0] SEG_C     = 8'h04;
  localparam logic [7:0] SEG_D     = 8'h08;
  localparam logic [7:0] SEG_E     = 8'h10;
  localparam logic [7:0] SEG_F     = 8'h20;
  localparam logic [7:0] SEG_G     = 8'h40;
  localparam logic [7:0] SEG_DP    = 8'h80;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_ALL7  = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;

  typedef enum logic [1:0] {
    MODE_HEART = 2'd0,
    MODE_CHASE = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BLANK = 2'd3
  } mode_e;

  // Number of frames in one full cycle of each animation.
  function automatic int frame_count(input mode_e m, input int digits);
    int n;
    case (m)
      MODE_HEART: n = digits;
      MODE_CHASE: n = 2 * digits + 4;
      MODE_BLINK: n = 2;
      default:    n = 1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Frame prescaler: raises tick for one cycle every TICKS enabled clocks.
// When en drops on the terminal count the counter parks there, so the tick
// fires in the first cycle en comes back.
module tick_gen #(
  parameter int TICKS = 6_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count enabled clocks, wrapping to zero after the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg_anim_gen.sv
// Per-display 7-segment animation source feeding LED_mux.
// Selects heartbeat, chase, blink or blank at frame boundaries and drives
// registered segment codes plus frame/cycle status pulses.
module seg_anim_gen
  import seg_anim_pkg::*;
#(
  parameter int DIGITS     = 6,
  parameter int TICKS      = 6_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          mode,
  output logic [8*DIGITS-1:0] seg_out,
  output logic                frame_tick,
  output logic                cycle_done
);

  localparam int H  = DIGITS / 2;
  localparam int FW = $clog2(2 * DIGITS + 4);
  localparam int SW = 8 * DIGITS;

  // Turn (animation, frame) into the full segment vector at output polarity.
  function automatic logic [SW-1:0] decode(input mode_e m, input logic [FW-1:0] f);
    logic [SW-1:0] pat;
    int            fi;
    int            k;
    pat = '0;
    fi  = int'(f);
    k   = 0;
    case (m)
      MODE_HEART: begin
        if (fi < 2 * H) begin
          k = (fi < H) ? fi : (2 * H - 1 - fi);
          pat[8*(H+k)   +: 8] = SEG_E | SEG_F;
          pat[8*(H-1-k) +: 8] = SEG_B | SEG_C;
        end
      end
      MODE_CHASE: begin
        if (fi < DIGITS)                 pat[8*(DIGITS-1-fi) +: 8] = SEG_A;
        else if (fi == DIGITS)           pat[7:0]                  = SEG_B;
        else if (fi == DIGITS + 1)       pat[7:0]                  = SEG_C;
        else if (fi < 2 * DIGITS + 2)    pat[8*(fi-DIGITS-2) +: 8] = SEG_D;
        else if (fi == 2 * DIGITS + 2)   pat[SW-1 -: 8]            = SEG_E;
        else if (fi == 2 * DIGITS + 3)   pat[SW-1 -: 8]            = SEG_F;
      end
      MODE_BLINK: begin
        if (fi == 0) pat = {DIGITS{SEG_ALL7}};
      end
      default: pat = '0;
    endcase
    return ACTIVE_LOW ? ~pat : pat;
  endfunction

  logic            tick;
  mode_e           mode_q;
  mode_e           mode_d;
  logic [FW-1:0]   frame_q;
  logic [FW-1:0]   frame_d;
  logic [FW-1:0]   last_frame;
  logic            wrap;
  logic [SW-1:0]   pattern;

  tick_gen #(
    .TICKS (TICKS)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  // Active animation and frame index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_HEART;
      frame_q <= '0;
    end else begin
      mode_q  <= mode_d;
      frame_q <= frame_d;
    end
  end

  // On tick either adopt a new animation from frame 0 or step the frame;
  // a single-frame animation never reports a wrap since nothing cycles.
  always_comb begin
    mode_d     = mode_q;
    frame_d    = frame_q;
    wrap       = 1'b0;
    last_frame = FW'(frame_count(mode_q, DIGITS) - 1);
    if (tick) begin
      if (mode_e'(mode) != mode_q) begin
        mode_d  = mode_e'(mode);
        frame_d = '0;
      end else if (frame_q == last_frame) begin
        frame_d = '0;
        wrap    = (last_frame != '0);
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  // Decode the upcoming frame so the registered output lands with the frame.
  always_comb begin
    pattern = decode(mode_d, frame_d);
  end

  // Register all outputs so they never depend combinationally on inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= decode(MODE_HEART, '0);
      frame_tick <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      seg_out    <= pattern;
      frame_tick <= tick;
      cycle_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_anim_gen.sv
// Directed bench for seg_anim_gen with DIGITS=6, TICKS=4.
// Main instance is active-high; a second active-low instance covers polarity
// and the blank animation. Inputs change and outputs are sampled on negedges.
module tb_seg_anim_gen;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [1:0]  mode_low;
  logic [47:0] seg_out;
  logic        frame_tick;
  logic        cycle_done;
  logic [47:0] seg_low;
  logic        frame_tick_low;
  logic        cycle_done_low;

  int vectors;
  int miscompares;

  logic [47:0] chase_exp [16];

  seg_anim_gen #(.DIGITS(6), .TICKS(4), .ACTIVE_LOW(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .seg_out    (seg_out),
    .frame_tick (frame_tick),
    .cycle_done (cycle_done)
  );

  seg_anim_gen #(.DIGITS(6), .TICKS(4), .ACTIVE_LOW(1'b1)) dut_low (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode_low),
    .seg_out    (seg_low),
    .frame_tick (frame_tick_low),
    .cycle_done (cycle_done_low)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    step(2);
    vectors++; if (seg_out !== 48'h0000_3006_0000) begin miscompares++; $display("[TB] FAIL reset_seg: got %h expected %h", seg_out, 48'h0000_3006_0000); end
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame_tick: got %b expected 0", frame_tick); end
    vectors++; if (cycle_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cycle_done: got %b expected 0", cycle_done); end
    vectors++; if (seg_low !== 48'hFFFF_CFF9_FFFF) begin miscompares++; $display("[TB] FAIL reset_seg_low: got %h expected %h", seg_low, 48'hFFFF_CFF9_FFFF); end
    rst_n = 1'b1;
  endtask

  task automatic test_heartbeat;
    step(4);
    vectors++; if (seg_out !== 48'h0030_0000_0600) begin miscompares++; $display("[TB] FAIL heart_f1: got %h expected %h", seg_out, 48'h0030_0000_0600); end
    vectors++; if (frame_tick !== 1'b1) begin miscompares++; $display("[TB] FAIL heart_first_tick: got %b expected 1", frame_tick); end
    vectors++; if (cycle_done !== 1'b0) begin miscompares++; $display("[TB] FAIL heart_f1_done: got %b expected 0", cycle_done); end
    step(1);
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("[TB] FAIL heart_tick_width: got %b expected 0", frame_tick); end
    step(3);
    vectors++; if (seg_out !== 48'h3000_0000_0006) begin miscompares++; $display("[TB] FAIL heart_f2: got %h expected %h", seg_out, 48'h3000_0000_0006); end
    step(12);
    vectors++; if (seg_out !== 48'h0000_3006_0000) begin miscompares++; $display("[TB] FAIL heart_f5: got %h expected %h", seg_out, 48'h0000_3006_0000); end
    vectors++; if (cycle_done !== 1'b0) begin miscompares++; $display("[TB] FAIL heart_f5_done: got %b expected 0", cycle_done); end
    step(4);
    vectors++; if (seg_out !== 48'h0000_3006_0000) begin miscompares++; $display("[TB] FAIL heart_wrap_seg: got %h expected %h", seg_out, 48'h0000_3006_0000); end
    vectors++; if (cycle_done !== 1'b1) begin miscompares++; $display("[TB] FAIL heart_wrap_done: got %b expected 1", cycle_done); end
    step(1);
    vectors++; if (cycle_done !== 1'b0) begin miscompares++; $display("[TB] FAIL heart_done_width: got %b expected 0", cycle_done); end
    step(3);
    vectors++; if (seg_out !== 48'h0030_0000_0600) begin miscompares++; $display("[TB] FAIL heart_f1_again: got %h expected %h", seg_out, 48'h0030_0000_0600); end
  endtask

  task automatic test_chase;
    mode = 2'd1;
    step(1);
    vectors++; if (seg_out !== 48'h0030_0000_0600) begin miscompares++; $display("[TB] FAIL chase_midframe_hold: got %h expected %h", seg_out, 48'h0030_0000_0600); end
    step(3);
    vectors++; if (seg_out !== chase_exp[0]) begin miscompares++; $display("[TB] FAIL chase_switch: got %h expected %h", seg_out, chase_exp[0]); end
    vectors++; if (cycle_done !== 1'b0) begin miscompares++; $display("[TB] FAIL chase_switch_done: got %b expected 0", cycle_done); end
    vectors++; if (frame_tick !== 1'b1) begin miscompares++; $display("[TB] FAIL chase_switch_tick: got %b expected 1", frame_tick); end
    for (int f = 1; f < 16; f++) begin
      step(4);
      vectors++; if (seg_out !== chase_exp[f]) begin miscompares++; $display("[TB] FAIL chase_f%0d: got %h expected %h", f, seg_out, chase_exp[f]); end
      vectors++; if (cycle_done !== 1'b0) begin miscompares++; $display("[TB] FAIL chase_f%0d_done: got %b expected 0", f, cycle_done); end
    end
    step(4);
    vectors++; if (seg_out !== chase_exp[0]) begin miscompares++; $display("[TB] FAIL chase_wrap_seg: got %h expected %h", seg_out, chase_exp[0]); end
    vectors++; if (cycle_done !== 1'b1) begin miscompares++; $display("[TB] FAIL chase_wrap_done: got %b expected 1", cycle_done); end
  endtask

  task automatic test_blink;
    mode = 2'd2;
    step(4);
    vectors++; if (seg_out !== 48'h7F7F_7F7F_7F7F) begin miscompares++; $display("[TB] FAIL blink_f0: got %h expected %h", seg_out, 48'h7F7F_7F7F_7F7F); end
    vectors++; if (cycle_done !== 1'b0) begin miscompares++; $display("[TB] FAIL blink_switch_done: got %b expected 0", cycle_done); end
    step(4);
    vectors++; if (seg_out !== 48'h0) begin miscompares++; $display("[TB] FAIL blink_f1: got %h expected %h", seg_out, 48'h0); end
    step(4);
    vectors++; if (seg_out !== 48'h7F7F_7F7F_7F7F) begin miscompares++; $display("[TB] FAIL blink_wrap_seg: got %h expected %h", seg_out, 48'h7F7F_7F7F_7F7F); end
    vectors++; if (cycle_done !== 1'b1) begin miscompares++; $display("[TB] FAIL blink_wrap_done: got %b expected 1", cycle_done); end
  endtask

  task automatic test_blank_active_low;
    int pulses;
    pulses   = 0;
    mode_low = 2'd3;
    step(4);
    vectors++; if (seg_low !== 48'hFFFF_FFFF_FFFF) begin miscompares++; $display("[TB] FAIL blank_low_seg: got %h expected %h", seg_low, 48'hFFFF_FFFF_FFFF); end
    vectors++; if (frame_tick_low !== 1'b1) begin miscompares++; $display("[TB] FAIL blank_low_tick: got %b expected 1", frame_tick_low); end
    vectors++; if (cycle_done_low !== 1'b0) begin miscompares++; $display("[TB] FAIL blank_low_switch_done: got %b expected 0", cycle_done_low); end
    repeat (12) begin
      step(1);
      if (cycle_done_low === 1'b1) pulses++;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("[TB] FAIL blank_low_no_done: got %0d pulses expected 0", pulses); end
    vectors++; if (seg_low !== 48'hFFFF_FFFF_FFFF) begin miscompares++; $display("[TB] FAIL blank_low_hold: got %h expected %h", seg_low, 48'hFFFF_FFFF_FFFF); end
  endtask

  task automatic test_enable_stall;
    step(2);
    en = 1'b0;
    step(5);
    vectors++; if (seg_out !== 48'h7F7F_7F7F_7F7F) begin miscompares++; $display("[TB] FAIL stall_hold_seg: got %h expected %h", seg_out, 48'h7F7F_7F7F_7F7F); end
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_no_tick: got %b expected 0", frame_tick); end
    step(5);
    en = 1'b1;
    step(1);
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_resume_early: got %b expected 0", frame_tick); end
    vectors++; if (seg_out !== 48'h7F7F_7F7F_7F7F) begin miscompares++; $display("[TB] FAIL stall_resume_seg: got %h expected %h", seg_out, 48'h7F7F_7F7F_7F7F); end
    step(1);
    vectors++; if (frame_tick !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_stretched_tick: got %b expected 1", frame_tick); end
    vectors++; if (seg_out !== 48'h0) begin miscompares++; $display("[TB] FAIL stall_stretched_seg: got %h expected %h", seg_out, 48'h0); end
    step(3);
    en = 1'b0;
    step(5);
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("[TB] FAIL suppress_tick: got %b expected 0", frame_tick); end
    vectors++; if (seg_out !== 48'h0) begin miscompares++; $display("[TB] FAIL suppress_seg: got %h expected %h", seg_out, 48'h0); end
    en = 1'b1;
    step(1);
    vectors++; if (frame_tick !== 1'b1) begin miscompares++; $display("[TB] FAIL suppress_release_tick: got %b expected 1", frame_tick); end
    vectors++; if (seg_out !== 48'h7F7F_7F7F_7F7F) begin miscompares++; $display("[TB] FAIL suppress_release_seg: got %h expected %h", seg_out, 48'h7F7F_7F7F_7F7F); end
    vectors++; if (cycle_done !== 1'b1) begin miscompares++; $display("[TB] FAIL suppress_release_done: got %b expected 1", cycle_done); end
  endtask

  task automatic test_reset_mid_chase;
    mode = 2'd1;
    step(4);
    vectors++; if (seg_out !== chase_exp[0]) begin miscompares++; $display("[TB] FAIL rchase_f0: got %h expected %h", seg_out, chase_exp[0]); end
    step(4);
    vectors++; if (seg_out !== chase_exp[1]) begin miscompares++; $display("[TB] FAIL rchase_f1: got %h expected %h", seg_out, chase_exp[1]); end
    step(2);
    rst_n = 1'b0;
    #1;
    vectors++; if (seg_out !== 48'h0000_3006_0000) begin miscompares++; $display("[TB] FAIL async_reset_seg: got %h expected %h", seg_out, 48'h0000_3006_0000); end
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_tick: got %b expected 0", frame_tick); end
    vectors++; if (seg_low !== 48'hFFFF_CFF9_FFFF) begin miscompares++; $display("[TB] FAIL async_reset_seg_low: got %h expected %h", seg_low, 48'hFFFF_CFF9_FFFF); end
    step(1);
    rst_n = 1'b1;
    step(3);
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("[TB] FAIL restart_early_tick: got %b expected 0", frame_tick); end
    vectors++; if (seg_out !== 48'h0000_3006_0000) begin miscompares++; $display("[TB] FAIL restart_hold_seg: got %h expected %h", seg_out, 48'h0000_3006_0000); end
    step(1);
    vectors++; if (frame_tick !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_first_tick: got %b expected 1", frame_tick); end
    vectors++; if (seg_out !== chase_exp[0]) begin miscompares++; $display("[TB] FAIL restart_chase_switch: got %h expected %h", seg_out, chase_exp[0]); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    vectors      = 0;
    miscompares  = 0;
    chase_exp[0]  = 48'h0100_0000_0000;
    chase_exp[1]  = 48'h0001_0000_0000;
    chase_exp[2]  = 48'h0000_0100_0000;
    chase_exp[3]  = 48'h0000_0001_0000;
    chase_exp[4]  = 48'h0000_0000_0100;
    chase_exp[5]  = 48'h0000_0000_0001;
    chase_exp[6]  = 48'h0000_0000_0002;
    chase_exp[7]  = 48'h0000_0000_0004;
    chase_exp[8]  = 48'h0000_0000_0008;
    chase_exp[9]  = 48'h0000_0000_0800;
    chase_exp[10] = 48'h0000_0008_0000;
    chase_exp[11] = 48'h0000_0800_0000;
    chase_exp[12] = 48'h0008_0000_0000;
    chase_exp[13] = 48'h0800_0000_0000;
    chase_exp[14] = 48'h1000_0000_0000;
    chase_exp[15] = 48'h2000_0000_0000;
    clk      = 1'b0;
    rst_n    = 1'b0;
    en       = 1'b1;
    mode     = 2'd0;
    mode_low = 2'd0;
    test_reset;
    test_heartbeat;
    test_chase;
    test_blink;
    test_blank_active_low;
    test_enable_stall;
    test_reset_mid_chase;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
